pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage rv32i pipeline. Drives load_*/flush_* of PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
// - Merges three hazard sources: multi-cycle I/D memory waits, load-use RAW hazards, and EX-stage taken-branch redirects.
// - Tracks partially-completed memory responses so a split I/D stall releases exactly once.
// PARAMETERS
// - REG_AW, default 5: register address width.
// - CNT_W, default 32: perf counter width (used only with HAZARD_PERF_EN).
// PORTS
// - clk            in   1       clock
// - rst            in   1       reset, asynchronous, active-high
// - imem_read      in   1       IF fetch outstanding; held high until imem_resp
// - imem_resp      in   1       I-side response, 1-cycle pulse
// - dmem_req       in   1       MEM stage load/store outstanding; held until dmem_resp
// - dmem_resp      in   1       D-side response, 1-cycle pulse
// - id_rs1_addr    in   REG_AW  ID-stage rs1
// - id_rs2_addr    in   REG_AW  ID-stage rs2
// - id_uses_rs1    in   1       ID instruction reads rs1
// - id_uses_rs2    in   1       ID instruction reads rs2
// - ex_rd          in   REG_AW  EX-stage destination
// - ex_mem_read    in   1       EX instruction is a load
// - ex_br_taken    in   1       EX redirect (taken branch/jal/jalr)
// - load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb   out  1 each  stage enables
// - flush_if_id, flush_id_ex    out  1 each  bubble insert; only effective with matching load_* = 1
// - stalled        out  1       memory stall in progress
// - stall_cycles, bubble_cnt, flush_cnt   out  CNT_W each  perf counters
// BEHAVIOUR
// - State: FSM {RUN, WAIT} plus flags i_done, d_done. Reset value: RUN, flags 0.
// - While rst is high, all outputs are 0.
// - i_ok  = ~imem_read | imem_resp | i_done
// - d_ok  = ~dmem_req  | dmem_resp | d_done
// - mem_stall = ~(i_ok & d_ok). This is combinational, so a 0-latency response never stalls.
// - Precedence, highest first:
//   1. mem_stall: all load_* = 0, flush_* = 0, stalled = 1.
//   2. ex_br_taken: all load_* = 1, flush_if_id = 1, flush_id_ex = 1.
//   3. load-use hazard, defined as ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1_addr == ex_rd) | (id_uses_rs2 & id_rs2_addr == ex_rd)):
//      load_pc = 0, load_if_id = 0, load_id_ex = 1, flush_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1.
//   4. Otherwise: all load_* = 1, flush_* = 0.
// - Outputs are combinational from state and inputs. Zero added latency.
// - FSM, RUN -> WAIT: when mem_stall. Set i_done if imem_resp arrived this cycle; same rule for d_done.
// - FSM, WAIT: set i_done on imem_resp and d_done on dmem_resp; flags are sticky.
// - FSM, WAIT -> RUN: in the release cycle (mem_stall = 0). Clear both flags. The pipeline advances this same cycle.
// - Requester rule: a request still high in the cycle after its response is a NEW request.
// - A branch or load-use hazard present during a stall is held by the frozen EX register. It is acted on in the release cycle; no extra latch is needed.
// - Simultaneous imem_resp and dmem_resp in WAIT: release that cycle.
// - A response pulse with no matching request pending is ignored; no flag is set.
// - Async reset mid-WAIT: immediately RUN, flags cleared, outputs 0. Outstanding memory transactions are the requesters' responsibility.
// CONFIGURATION
// - Macro HAZARD_PERF_EN.
// - Defined:
//   - stall_cycles increments each cycle stalled = 1.
//   - bubble_cnt increments on each load-use bubble.
//   - flush_cnt increments on each branch flush.
//   - All three saturate at all-ones and reset to 0.
// - Undefined: the ports remain, tied to 0, and no counter logic is built.
// TESTING
// - Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle of load_pc = 0, load_if_id = 0, flush_id_ex = 1; the next cycle is all load_* = 1.
// - x0 filter: ex_rd = 0, ex_mem_read = 1, id_rs1_addr = 0 -> no bubble.
// - Split stall: dmem_req at t0; imem_resp at t1, dmem_resp at t4 -> stalled at t0..t3, loads high at t4. Exactly 1 release.
// - Stall then branch: ex_br_taken held during a 3-cycle dmem stall -> flush_if_id = flush_id_ex = 1 only in the release cycle.
// - Branch plus load-use in the same cycle -> branch wins: load_pc = 1, both flushes = 1.
// - Reset mid-WAIT, then a fresh 2-cycle imem wait -> stall_cycles = 2 (HAZARD_PERF_EN defined).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: merges memory waits, load-use and branch redirects.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stalled,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t state_q, state_d;
  logic   i_done_q, i_done_d;
  logic   d_done_q, d_done_d;

  logic i_ok, d_ok, mem_stall;
  logic i_hit, d_hit;
  logic rs1_hit, rs2_hit, load_use;
  logic br_sel, lu_sel;

  // A response only counts when its request is actually pending.
  assign i_hit = imem_read & imem_resp;
  assign d_hit = dmem_req & dmem_resp;

  assign i_ok      = ~imem_read | imem_resp | i_done_q;
  assign d_ok      = ~dmem_req  | dmem_resp | d_done_q;
  assign mem_stall = ~(i_ok & d_ok);

  assign rs1_hit  = id_uses_rs1 & (id_rs1_addr == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2_addr == ex_rd);
  assign load_use = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

  assign br_sel = ~rst & ~mem_stall & ex_br_taken;
  assign lu_sel = ~rst & ~mem_stall & ~ex_br_taken & load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    case (state_q)
      ST_RUN: begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        if (mem_stall) begin
          state_d  = ST_WAIT;
          i_done_d = i_hit;
          d_done_d = d_hit;
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          i_done_d = i_done_q | i_hit;
          d_done_d = d_done_q | d_hit;
        end else begin
          // Release cycle: the pipeline advances now, so any request still high next cycle is new.
          state_d  = ST_RUN;
          i_done_d = 1'b0;
          d_done_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_RUN;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stalled     = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stalled = 1'b1;
      end else if (ex_br_taken) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push a bubble into EX.
        load_id_ex  = 1'b1;
        flush_id_ex = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) sat_inc = v + 1'b1;
    else                 sat_inc = v;
  endfunction

  always_comb begin
    stall_d  = sat_inc(stall_q, stalled);
    bubble_d = sat_inc(bubble_q, lu_sel);
    flush_d  = sat_inc(flush_q, br_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_cnt   = bubble_q;
  assign flush_cnt    = flush_q;
`else
  logic unused_sel;
  assign unused_sel   = br_sel ^ lu_sel;
  assign stall_cycles = '0;
  assign bubble_cnt   = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by randomized requesters.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, stalled;
  logic [CW-1:0] stall_cycles, bubble_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stalled(stalled),
    .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [7:0]    ctl;   // {load_pc,load_if_id,load_id_ex,load_ex_mem,load_mem_wb,flush_if_id,flush_id_ex,stalled}
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
    logic [CW-1:0] fc;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  // Reference model: a memory stall lasts until every side that was waiting has seen
  // its response at some point since the stall began.
  bit            got_i = 0, got_d = 0;
  logic [CW-1:0] m_sc = '0, m_bc = '0, m_fc = '0;

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
    return (PERF && v != {CW{1'b1}}) ? v + 1'b1 : v;
  endfunction

  task automatic cyc(input logic r, ir, irsp, dr, drsp, br, mr, u1, u2,
                     input logic [AW-1:0] rs1, rs2, rd);
    exp_t e;
    bit   i_sat, d_sat, stall, lu;
    @(posedge clk); #1;
    rst = r; imem_read = ir; imem_resp = irsp; dmem_req = dr; dmem_resp = drsp;
    ex_br_taken = br; ex_mem_read = mr; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rs1_addr = rs1; id_rs2_addr = rs2; ex_rd = rd;
    e.cyc = cyc_n;
    cyc_n++;
    if (r) begin
      got_i = 0; got_d = 0; m_sc = '0; m_bc = '0; m_fc = '0;
      e.ctl = 8'b0; e.sc = '0; e.bc = '0; e.fc = '0;
    end else begin
      i_sat = !ir || irsp || got_i;
      d_sat = !dr || drsp || got_d;
      stall = !(i_sat && d_sat);
      lu    = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.sc = m_sc; e.bc = m_bc; e.fc = m_fc;
      if (stall)   e.ctl = 8'b00000_00_1;
      else if (br) e.ctl = 8'b11111_11_0;
      else if (lu) e.ctl = 8'b00111_01_0;
      else         e.ctl = 8'b11111_00_0;
      if (stall) begin
        got_i = got_i || (ir && irsp);
        got_d = got_d || (dr && drsp);
        m_sc  = bump(m_sc);
      end else begin
        got_i = 0; got_d = 0;
        if (br)      m_fc = bump(m_fc);
        else if (lu) m_bc = bump(m_bc);
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0,0,0,0,0,0,0,0,0,'0,'0,'0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, stalled};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctl);
        end
        checks++;
        if ({stall_cycles, bubble_cnt, flush_cnt} !== {e.sc, e.bc, e.fc}) begin
          errors++;
          $display("FAIL perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.cyc,
                   stall_cycles, bubble_cnt, flush_cnt, e.sc, e.bc, e.fc);
        end
      end
    end
  end

  initial begin
    bit ia = 0, da = 0;
    int il = 0, dl = 0;
    logic irsp, drsp, r;

    cyc(1,0,0,0,0,0,0,0,0,'0,'0,'0);
    cyc(1,1,0,1,0,1,1,1,1,5'd3,5'd3,5'd3);
    idle(2);
    // Load-use: EX lw x5, ID add x6,x5,x1, then the hazard clears
    cyc(0,0,0,0,0,0,1,1,1,5'd5,5'd1,5'd5);
    cyc(0,0,0,0,0,0,0,1,1,5'd5,5'd1,5'd6);
    // rs2 match, and x0 destination filter
    cyc(0,0,0,0,0,0,1,0,1,5'd2,5'd7,5'd7);
    cyc(0,0,0,0,0,0,1,1,0,5'd0,5'd0,5'd0);
    cyc(0,0,0,0,0,0,1,0,0,5'd4,5'd4,5'd4);
    // Split stall: imem_resp at t1, dmem_resp at t4
    cyc(0,1,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,1,1,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,0,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,0,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,0,0,1,1,0,0,0,0,'0,'0,'0);
    idle(1);
    // Zero-latency responses never stall; both responses at once release
    cyc(0,1,1,1,1,0,0,0,0,'0,'0,'0);
    cyc(0,1,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,1,1,1,1,0,0,0,0,'0,'0,'0);
    // Stray response pulses with no request
    cyc(0,0,1,0,1,0,0,0,0,'0,'0,'0);
    // Branch held across a 3-cycle dmem stall
    for (int k = 0; k < 3; k++) cyc(0,0,0,1,0,1,0,0,0,'0,'0,'0);
    cyc(0,0,0,1,1,1,0,0,0,'0,'0,'0);
    idle(1);
    // Branch and load-use together
    cyc(0,0,0,0,0,1,1,1,0,5'd9,5'd0,5'd9);
    // Reset mid-WAIT, then a fresh 2-cycle imem wait
    cyc(0,0,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(0,0,0,1,0,0,0,0,0,'0,'0,'0);
    cyc(1,0,0,1,0,0,0,0,0,'0,'0,'0);
    idle(1);
    cyc(0,1,0,0,0,0,0,0,0,'0,'0,'0);
    cyc(0,1,0,0,0,0,0,0,0,'0,'0,'0);
    cyc(0,1,1,0,0,0,0,0,0,'0,'0,'0);
    idle(1);

    for (int n = 0; n < 1500; n++) begin
      if (!ia && ($urandom % 4 == 0)) begin ia = 1; il = int'($urandom % 4); end
      if (!da && ($urandom % 4 == 0)) begin da = 1; dl = int'($urandom % 5); end
      irsp = ia ? (il == 0) : ($urandom % 20 == 0);
      drsp = da ? (dl == 0) : ($urandom % 20 == 0);
      r    = ($urandom % 250 == 0);
      cyc(r, ia, irsp, da, drsp, $urandom % 5 == 0, $urandom % 2 == 0,
          $urandom % 2 == 0, $urandom % 2 == 0,
          AW'($urandom % 4), AW'($urandom % 4), AW'($urandom % 4));
      if (ia) begin
        if (il == 0) begin ia = ($urandom % 3 == 0); il = int'($urandom % 4); end
        else il--;
      end
      if (da) begin
        if (dl == 0) begin da = ($urandom % 3 == 0); dl = int'($urandom % 5); end
        else dl--;
      end
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
